// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT datapath blocks.
//   BFLY_LAT       : register stages in the radix-2 butterfly
//   prod_w/sum_w   : internal full-precision widths for given data/twiddle widths
//   round_limit    : round-half-up, arithmetic shift and range limiting of a
//                    wide intermediate, with an out-of-range indication
// All wide intermediates are carried in a 64-bit signed container, so
// DATA_W + TW_W + 3 must not exceed 64.
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int BFLY_LAT = 3;
  localparam int MAX_W    = 64;

  typedef logic signed [MAX_W-1:0] wide_t;

  typedef struct packed {
    wide_t value;
    logic  oor;
  } rs_t;

  // One full-precision complex product term: DATA_W x (TW_W+1).
  function automatic int prod_w(input int dw, input int tw);
    return dw + tw + 1;
  endfunction

  // xp aligned to the twiddle fraction: xp << (TW_W-2).
  function automatic int xpa_w(input int dw, input int tw);
    return dw + tw - 2;
  endfunction

  // xp +/- (xq*W) sums; enough headroom that S1/S2 never truncate.
  function automatic int sum_w(input int dw, input int tw);
    return dw + tw + 3;
  endfunction

  // Add half an LSB of the result, then shift: ties round toward +inf.
  function automatic wide_t round_half_up(input wide_t v, input int unsigned sh);
    wide_t bias;
    bias = '0;
    if (sh != 0) bias = wide_t'(1) <<< (sh - 1);
    return (v + bias) >>> sh;
  endfunction

  // Round by sh, then limit to a signed w-bit range. When sat is clear the
  // value is returned unclamped and the caller keeps its low w bits (wrap).
  function automatic rs_t round_limit(input wide_t v, input int unsigned sh,
                                      input int unsigned w, input logic sat);
    wide_t r;
    wide_t lim;
    rs_t   res;
    r         = round_half_up(v, sh);
    lim       = wide_t'(1) <<< (w - 1);
    res.oor   = (r >= lim) || (r < -lim);
    res.value = r;
    if (res.oor && sat) res.value = r[MAX_W-1] ? -lim : (lim - wide_t'(1));
    return res;
  endfunction

endpackage

// File: rtl/bfly_round_sat.sv
// ---------------------------------------------------------------------------
// bfly_round_sat
// Final stage of one butterfly output component: rounds the full-precision
// sum back to DATA_W, optionally with an extra /2, and limits the result.
// Purely combinational; the caller registers y and oor.
// Ports:
//   sum   in  SUM_W  full-precision sum, Q(TW_W-2) fraction
//   scale in  1      1 = additional divide by 2
//   y     out DATA_W rounded, saturated (SAT_EN=1) or wrapped (SAT_EN=0)
//   oor   out 1      rounded value did not fit in DATA_W
// ---------------------------------------------------------------------------
import fft_pkg::*;

module bfly_round_sat #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 15,
  parameter bit SAT_EN = 1'b1,
  parameter int SUM_W  = sum_w(DATA_W, TW_W)
) (
  input  logic signed [SUM_W-1:0]  sum,
  input  logic                     scale,
  output logic signed [DATA_W-1:0] y,
  output logic                     oor
);

  localparam int unsigned FRAC = TW_W - 2;

  rs_t         rs;
  int unsigned sh;

  always_comb begin
    sh  = FRAC;
    if (scale) sh = FRAC + 1;
    rs  = round_limit(wide_t'(sum), sh, DATA_W, SAT_EN);
    y   = rs.value[DATA_W-1:0];
    oor = rs.oor;
  end

endmodule

// File: rtl/butterfly_r2_pipe.sv
// ---------------------------------------------------------------------------
// butterfly_r2_pipe
// Radix-2 DIT butterfly, three register stages, full-pipeline stall:
//   yp = xp + xq*W,  yq = xp - xq*W   (W conjugated when inv = 1)
// S1 multiplies, S2 adds at full precision, S3 rounds/limits into the
// output registers. All stages advance together when the output slot is
// empty or being taken.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready = pipeline advance)
//   xp_*, xq_*  [DATA_W]     input samples, signed
//   tw_*        [TW_W]       twiddle, signed Q2.(TW_W-2)
//   inv, scale               per-sample conjugate-twiddle / divide-by-2
//   out_valid/out_ready      output handshake
//   yp_*, yq_*  [DATA_W]     results, held while stalled
//   ovf, ovf_clr             sticky overflow and its clear (set wins)
// ---------------------------------------------------------------------------
import fft_pkg::*;

module butterfly_r2_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 15,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] xp_real,
  input  logic signed [DATA_W-1:0] xp_imag,
  input  logic signed [DATA_W-1:0] xq_real,
  input  logic signed [DATA_W-1:0] xq_imag,
  input  logic signed [TW_W-1:0]   tw_real,
  input  logic signed [TW_W-1:0]   tw_imag,
  input  logic                     inv,
  input  logic                     scale,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] yp_real,
  output logic signed [DATA_W-1:0] yp_imag,
  output logic signed [DATA_W-1:0] yq_real,
  output logic signed [DATA_W-1:0] yq_imag,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int PROD_W = prod_w(DATA_W, TW_W);
  localparam int XPA_W  = xpa_w(DATA_W, TW_W);
  localparam int SUM_W  = sum_w(DATA_W, TW_W);

  logic adv;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // ---------------- S1: twiddle select and products ----------------
  // Imag twiddle is widened by one bit so negating the most negative
  // value (inverse mode) stays exact.
  logic signed [TW_W:0]   tw_i_ext;
  logic signed [TW_W:0]   wi;
  logic signed [PROD_W-1:0] pr0_d, pr1_d, pi0_d, pi1_d;
  logic signed [XPA_W-1:0]  xpa_r_d, xpa_i_d;

  assign tw_i_ext = (TW_W+1)'(tw_imag);
  assign wi       = inv ? -tw_i_ext : tw_i_ext;

  assign pr0_d   = PROD_W'(xq_real) * PROD_W'(tw_real);
  assign pr1_d   = PROD_W'(xq_imag) * PROD_W'(wi);
  assign pi0_d   = PROD_W'(xq_real) * PROD_W'(wi);
  assign pi1_d   = PROD_W'(xq_imag) * PROD_W'(tw_real);
  assign xpa_r_d = XPA_W'(xp_real) <<< (TW_W - 2);
  assign xpa_i_d = XPA_W'(xp_imag) <<< (TW_W - 2);

  logic                     s1_valid;
  logic                     s1_scale;
  logic signed [PROD_W-1:0] s1_pr0, s1_pr1, s1_pi0, s1_pi1;
  logic signed [XPA_W-1:0]  s1_xpa_r, s1_xpa_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_pr0   <= '0;
      s1_pr1   <= '0;
      s1_pi0   <= '0;
      s1_pi1   <= '0;
      s1_xpa_r <= '0;
      s1_xpa_i <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_scale <= scale;
      s1_pr0   <= pr0_d;
      s1_pr1   <= pr1_d;
      s1_pi0   <= pi0_d;
      s1_pi1   <= pi1_d;
      s1_xpa_r <= xpa_r_d;
      s1_xpa_i <= xpa_i_d;
    end
  end

  // ---------------- S2: complex product and butterfly sums ----------------
  logic signed [SUM_W-1:0] t_r, t_i;
  logic signed [SUM_W-1:0] xpw_r, xpw_i;
  logic signed [SUM_W-1:0] sp_r_d, sp_i_d, sq_r_d, sq_i_d;

  assign t_r    = SUM_W'(s1_pr0) - SUM_W'(s1_pr1);
  assign t_i    = SUM_W'(s1_pi0) + SUM_W'(s1_pi1);
  assign xpw_r  = SUM_W'(s1_xpa_r);
  assign xpw_i  = SUM_W'(s1_xpa_i);
  assign sp_r_d = xpw_r + t_r;
  assign sp_i_d = xpw_i + t_i;
  assign sq_r_d = xpw_r - t_r;
  assign sq_i_d = xpw_i - t_i;

  logic                    s2_valid;
  logic                    s2_scale;
  logic signed [SUM_W-1:0] s2_sp_r, s2_sp_i, s2_sq_r, s2_sq_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_sp_r  <= '0;
      s2_sp_i  <= '0;
      s2_sq_r  <= '0;
      s2_sq_i  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_scale <= s1_scale;
      s2_sp_r  <= sp_r_d;
      s2_sp_i  <= sp_i_d;
      s2_sq_r  <= sq_r_d;
      s2_sq_i  <= sq_i_d;
    end
  end

  // ---------------- S3: round / limit into output registers ----------------
  logic signed [DATA_W-1:0] yp_r_d, yp_i_d, yq_r_d, yq_i_d;
  logic [3:0]               oor;

  bfly_round_sat #(.DATA_W(DATA_W), .TW_W(TW_W), .SAT_EN(SAT_EN), .SUM_W(SUM_W)) u_rs_yp_r (
    .sum(s2_sp_r), .scale(s2_scale), .y(yp_r_d), .oor(oor[0])
  );
  bfly_round_sat #(.DATA_W(DATA_W), .TW_W(TW_W), .SAT_EN(SAT_EN), .SUM_W(SUM_W)) u_rs_yp_i (
    .sum(s2_sp_i), .scale(s2_scale), .y(yp_i_d), .oor(oor[1])
  );
  bfly_round_sat #(.DATA_W(DATA_W), .TW_W(TW_W), .SAT_EN(SAT_EN), .SUM_W(SUM_W)) u_rs_yq_r (
    .sum(s2_sq_r), .scale(s2_scale), .y(yq_r_d), .oor(oor[2])
  );
  bfly_round_sat #(.DATA_W(DATA_W), .TW_W(TW_W), .SAT_EN(SAT_EN), .SUM_W(SUM_W)) u_rs_yq_i (
    .sum(s2_sq_i), .scale(s2_scale), .y(yq_i_d), .oor(oor[3])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      yp_real   <= '0;
      yp_imag   <= '0;
      yq_real   <= '0;
      yq_imag   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      yp_real   <= yp_r_d;
      yp_imag   <= yp_i_d;
      yq_real   <= yq_r_d;
      yq_imag   <= yq_i_d;
    end
  end

  // Only a valid slot moving into the output register can flag overflow;
  // a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (adv && s2_valid && (|oor)) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
module tb_butterfly_r2_pipe;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, inv, scale, out_valid, out_ready, ovf, ovf_clr;
  logic signed [15:0] xp_real, xp_imag, xq_real, xq_imag;
  logic signed [15:0] yp_real, yp_imag, yq_real, yq_imag;
  logic signed [14:0] tw_real, tw_imag;

  always #5 clk = ~clk;

  butterfly_r2_pipe #(.DATA_W(16), .TW_W(15), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .xp_real(xp_real), .xp_imag(xp_imag), .xq_real(xq_real), .xq_imag(xq_imag),
    .tw_real(tw_real), .tw_imag(tw_imag), .inv(inv), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .yp_real(yp_real), .yp_imag(yp_imag), .yq_real(yq_real), .yq_imag(yq_imag),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {
    int xpr, xpi, xqr, xqi, twr, twi;
    bit inv, scale;
    int ypr, ypi, yqr, yqi;
    bit ovf;
  } vec_t;

  vec_t tbl [13];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    xp_real = 16'(v.xpr); xp_imag = 16'(v.xpi);
    xq_real = 16'(v.xqr); xq_imag = 16'(v.xqi);
    tw_real = 15'(v.twr); tw_imag = 15'(v.twi);
    inv = v.inv; scale = v.scale;
  endtask

  // Single pair through an otherwise idle pipe; checks latency and results.
  // clr_on_out raises ovf_clr on the same edge the result reaches the output.
  task automatic run_vec(input vec_t v, input bit clr_on_out, input string tag);
    int lat;
    bit got;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      ovf_clr = clr_on_out && (lat == 2);
      got = out_valid;
    end
    ovf_clr = 1'b0;
    chk({tag, " latency"}, lat, 3);
    if (got) begin
      chk({tag, " yp_real"}, int'(yp_real), v.ypr);
      chk({tag, " yp_imag"}, int'(yp_imag), v.ypi);
      chk({tag, " yq_real"}, int'(yq_real), v.yqr);
      chk({tag, " yq_imag"}, int'(yq_imag), v.yqi);
      chk({tag, " ovf"}, int'(ovf), int'(v.ovf));
    end
  endtask

  task automatic clear_ovf();
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   sent, recv, stall_lo, seen;
    bit   prev_stall;
    logic signed [15:0] sv_pr, sv_pi, sv_qr, sv_qi;

    //          xpr     xpi   xqr    xqi  twr    twi    inv  scl  ypr     ypi   yqr   yqi  ovf
    tbl[0]  = '{100,    -40,  50,    20,  8192,  0,     1'b0,1'b0, 150,   -20,  50,   -60, 1'b0};
    tbl[1]  = '{0,      0,    50,    20,  0,     -8192, 1'b0,1'b0, 20,    -50,  -20,  50,  1'b0};
    tbl[2]  = '{0,      0,    50,    20,  0,     -8192, 1'b1,1'b0, -20,   50,   20,   -50, 1'b0};
    tbl[3]  = '{32767,  0,    32767, 0,   8192,  0,     1'b0,1'b0, 32767, 0,    0,    0,   1'b1};
    tbl[4]  = '{32767,  0,    32767, 0,   8192,  0,     1'b0,1'b1, 32767, 0,    0,    0,   1'b0};
    tbl[5]  = '{3,      -3,   0,     0,   8192,  0,     1'b0,1'b1, 2,     -1,   2,    -1,  1'b0};
    tbl[6]  = '{-32768, 0,    -32768,0,   8192,  0,     1'b0,1'b0, -32768,0,    0,    0,   1'b1};
    tbl[7]  = '{0,      0,    1000,  0,   5793,  -5793, 1'b0,1'b0, 707,   -707, -707, 707, 1'b0};
    tbl[8]  = '{0,      0,    0,     10,  0,     -16384,1'b1,1'b0, -20,   0,    20,   0,   1'b0};
    tbl[9]  = '{0,      0,    0,     10,  0,     -16384,1'b0,1'b0, 20,    0,    -20,  0,   1'b0};
    tbl[10] = '{0,      0,    1,     0,   4096,  0,     1'b0,1'b0, 1,     0,    0,    0,   1'b0};
    tbl[11] = '{1000,   2000, 300,   -400,8192,  0,     1'b1,1'b1, 650,   800,  350,  1200,1'b0};
    tbl[12] = '{1,      1,    3,     5,   0,     8192,  1'b0,1'b1, -2,    2,    3,    -1,  1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    drive(tbl[0]);
    repeat (3) @(negedge clk);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset ovf", int'(ovf), 0);
    chk("reset yp_real", int'(yp_real), 0);
    chk("reset yq_imag", int'(yq_imag), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", int'(in_ready), 1);

    for (int i = 0; i < 13; i++) begin
      clear_ovf();
      run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));
    end

    // sticky ovf: stays set across a clean result, then clears
    clear_ovf();
    run_vec(tbl[3], 1'b0, "sticky_set");
    v = tbl[0];
    v.ovf = 1'b1;
    run_vec(v, 1'b0, "sticky_hold");
    clear_ovf();
    chk("sticky_clear ovf", int'(ovf), 0);

    // set and clear on the same edge: set wins
    run_vec(tbl[6], 1'b1, "set_wins");
    @(negedge clk);
    chk("set_wins after ovf", int'(ovf), 1);
    clear_ovf();
    chk("set_wins clear ovf", int'(ovf), 0);

    // backpressure: 10 back-to-back pairs, out_ready low for 5 cycles
    sent = 0; recv = 0; stall_lo = 0; prev_stall = 1'b0;
    sv_pr = '0; sv_pi = '0; sv_qr = '0; sv_qi = '0;
    for (int c = 0; c < 80 && recv < 10; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 11);
      if (sent < 10) begin
        xp_real = 16'(sent * 10); xp_imag = 16'(-sent);
        xq_real = 16'(sent);      xq_imag = 16'(2 * sent);
        tw_real = 15'sd8192;      tw_imag = '0;
        inv = 1'b0; scale = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready) stall_lo++;
      if (prev_stall) begin
        chk("bp hold out_valid", int'(out_valid), 1);
        chk("bp hold yp_real", int'(yp_real), int'(sv_pr));
        chk("bp hold yp_imag", int'(yp_imag), int'(sv_pi));
        chk("bp hold yq_real", int'(yq_real), int'(sv_qr));
        chk("bp hold yq_imag", int'(yq_imag), int'(sv_qi));
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        chk("bp stall in_ready", int'(in_ready), 0);
        sv_pr = yp_real; sv_pi = yp_imag; sv_qr = yq_real; sv_qi = yq_imag;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp%0d yp_real", recv), int'(yp_real), 11 * recv);
        chk($sformatf("bp%0d yp_imag", recv), int'(yp_imag), recv);
        chk($sformatf("bp%0d yq_real", recv), int'(yq_real), 9 * recv);
        chk($sformatf("bp%0d yq_imag", recv), int'(yq_imag), -3 * recv);
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp sent", sent, 10);
    chk("bp received", recv, 10);
    chk("bp in_ready low cycles", stall_lo, 5);

    // reset with three saturating pairs in flight and ovf already set
    run_vec(tbl[3], 1'b0, "pre_rst");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(tbl[3]);
      in_valid = 1'b1;
      if (k == 3) begin
        #1;
        chk("pre_rst out_valid", int'(out_valid), 1);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst out_valid", int'(out_valid), 0);
    chk("mid_rst ovf", int'(ovf), 0);
    chk("mid_rst yp_real", int'(yp_real), 0);
    chk("mid_rst yp_imag", int'(yp_imag), 0);
    chk("mid_rst yq_real", int'(yq_real), 0);
    chk("mid_rst yq_imag", int'(yq_imag), 0);
    chk("mid_rst in_ready", int'(in_ready), 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || ovf) seen++;
    end
    chk("post_rst leftover slots", seen, 0);
    run_vec(tbl[0], 1'b0, "post_rst");
    run_vec(tbl[12], 1'b0, "post_rst2");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/butterfly_r2_pipe.md
Name: butterfly_r2_pipe

Overview:
Parametrised radix-2 DIT butterfly for the FFT datapath. It computes yp = xp + xq·W and yq = xp − xq·W on complex fixed-point samples. It adds the following over the previous butterfly:
- configurable data and twiddle widths
- a valid/ready handshake with full-pipeline stall
- an inverse (conjugate-twiddle) mode
- optional per-stage ÷2 scaling
- round-half-up with saturation, plus a sticky overflow flag

It sits between the FFT stage address generator/RAM read port and the stage write-back.

Parameters:
DATA_W, 16, signed width of every real/imag input and output sample
TW_W, 15, signed twiddle width; twiddle is Q2.(TW_W-2), so 1.0 = 2^(TW_W-2) (8192 at default)
SAT_EN, 1, 1 = saturate results to DATA_W; 0 = two's-complement wrap

Ports:
clk, in, 1, system clock
rst, in, 1, synchronous active-high reset
in_valid, in, 1, input sample pair and twiddle valid
in_ready, out, 1, block accepts input this cycle
xp_real, in, DATA_W, Xm(p) real, signed
xp_imag, in, DATA_W, Xm(p) imag, signed
xq_real, in, DATA_W, Xm(q) real, signed
xq_imag, in, DATA_W, Xm(q) imag, signed
tw_real, in, TW_W, twiddle real, signed Q2.(TW_W-2)
tw_imag, in, TW_W, twiddle imag, signed Q2.(TW_W-2)
inv, in, 1, 1 = use conj(W); sampled with the data
scale, in, 1, 1 = divide results by 2; sampled with the data
out_valid, out, 1, output pair valid
out_ready, in, 1, downstream accepts output
yp_real, out, DATA_W, Xm+1(p) real
yp_imag, out, DATA_W, Xm+1(p) imag
yq_real, out, DATA_W, Xm+1(q) real
yq_imag, out, DATA_W, Xm+1(q) imag
ovf, out, 1, sticky overflow: any result saturated or wrapped
ovf_clr, in, 1, clears ovf

Behaviour:
- Reset: the clock and reset are fixed as one clock `clk`, with reset `rst` synchronous and active-high. When rst is high at a clock edge:
  - all stage valid bits, out_valid, ovf and all y* outputs go to 0
  - in-flight data is discarded
  - reset mid-operation loses everything in flight; in_ready is 1 the cycle after reset.
- Pipeline: 3 register stages. Latency is exactly 3 cycles from accept (in_valid & in_ready) to out_valid when out_ready is held high. Throughput is 1 pair/cycle.
- Advance: adv = out_ready | ~out_valid.
  - All three stages shift together only when adv = 1.
  - in_ready = adv.
  - When adv = 0, every stage register, including the y* outputs, holds. Outputs are stable while out_valid & ~out_ready.
  - Bubbles propagate as valid = 0 slots; no compaction.
- S1 (multiply):
  - wi = inv ? −tw_imag : tw_imag, computed at TW_W+1 bits so that negating the most negative twiddle is exact.
  - Four products: pr0 = xq_r·tw_r, pr1 = xq_i·wi, pi0 = xq_r·wi, pi1 = xq_i·tw_r.
  - xp is aligned as xp << (TW_W-2).
  - scale is pipelined alongside the data.
- S2 (add): full-precision, with no truncation inside S1/S2.
  - t_r = pr0 − pr1, t_i = pi0 + pi1.
  - sums: xp_r ± t_r and xp_i ± t_i, computed at DATA_W+TW_W+3 bits.
- S3 (round/limit), per component:
  - sh = (TW_W-2) + scale.
  - Add 2^(sh-1), then arithmetic shift right by sh (round half toward +inf).
  - If the result is outside [−2^(DATA_W-1), 2^(DATA_W-1)−1]: clamp when SAT_EN = 1, else keep the low DATA_W bits. In either case set ovf.
- ovf:
  - Set on the S3→output transfer when any of the 4 components is out of range.
  - ovf_clr clears it. If set and clear coincide in the same cycle, set wins.
  - Held on stall; the update happens only when a valid slot advances.
- inv and scale are per-sample. Changing them between consecutive accepted samples affects only the samples they accompanied.
- y* values for out_valid = 0 slots are don't-care. The bench checks only valid outputs.

Decomposition:
- Package fft_pkg:
  - the BFLY_LAT = 3 constant
  - localparams for the product and sum widths as functions of DATA_W/TW_W
  - a rounding/saturation function shared with other FFT blocks.
- One natural sub-module, bfly_round_sat: one component's round, shift and limit, plus an out-of-range flag. It is instantiated 4× in S3.

Test Plan:
- Identity twiddle: W = (8192, 0), xp = (100, −40), xq = (50, 20), inv = 0, scale = 0 → after 3 cycles yp = (150, −20), yq = (50, −60), ovf = 0.
- −j twiddle with inverse: W = (0, −8192), xp = 0, xq = (50, 20).
  - inv = 0 → yp = (20, −50), yq = (−20, 50).
  - Same input with inv = 1 → yp = (−20, 50), yq = (20, −50).
- Saturation/scale: xp = xq = (32767, 0), W = (8192, 0).
  - scale = 0, SAT_EN = 1 → yp_real = 32767, yq_real = 0, ovf = 1.
  - ovf_clr pulse → ovf = 0.
  - scale = 1 → yp_real = 32767, ovf stays 0.
- Rounding: xp = (3, −3), xq = 0, scale = 1 → yp = (2, −1) (half rounds toward +inf).
- Backpressure: stream 10 pairs back-to-back and drop out_ready for 5 cycles mid-stream → in_ready low for the same cycles, y* stable while stalled, all 10 results in order, none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 3 pairs in flight → next cycle out_valid = 0, ovf = 0, y* = 0. Subsequent inputs produce correct results at latency 3.
